// File: rtl/bird_datapath.sv
// Bird datapath: owns the bird y position, reports ceiling/floor status to the
// controller and, once per frame tick, erases the sprite, moves the bird and
// redraws it through the VGA adapter pixel port, one pixel per cycle.
module bird_datapath #(
  parameter int         X_POS        = 40,
  parameter int         Y_START      = 60,
  parameter int         Y_MIN        = 8,
  parameter int         Y_GROUND     = 112,
  parameter int         SIZE         = 4,
  parameter int         RISE_STEP    = 2,
  parameter int         FALL_STEP    = 1,
  parameter int         FRAME_CYCLES = 833333,
  parameter logic [2:0] BIRD_COLOUR  = 3'b110,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] state_in,
  input  logic       pipe_hit,
  output logic       flag,
  output logic       touched,
  output logic [6:0] y_out,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int L    = $clog2(SIZE);
  localparam int CNTW = 2 * L + 1;
  localparam int NPIX = SIZE * SIZE;
  localparam int FCW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {M_START, M_RAISING, M_FALLING, M_STOP} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW} seq_t;

  mode_t            mode;
  seq_t             seq;
  logic [FCW-1:0]   frame_cnt;
  logic             tick;
  logic [CNTW-1:0]  cnt;
  logic [6:0]       y;
  logic [6:0]       y_next;
  logic [7:0]       fall_sum;
  logic [7:0]       pix_x;
  logic [6:0]       pix_y;

  assign tick  = (frame_cnt == FCW'(FRAME_CYCLES - 1));
  assign busy  = (seq != S_IDLE);
  assign y_out = y;
  assign flag  = (y <= 7'(Y_MIN));

  // Raster position of pixel index cnt: py is the high half, px the low half.
  assign pix_x = 8'(X_POS) + {{(8 - L){1'b0}}, cnt[L-1:0]};
  assign pix_y = y + {{(7 - L){1'b0}}, cnt[2*L-1:L]};

  // Fall addition in 8 bits so a step past the floor cannot wrap.
  assign fall_sum = {1'b0, y} + 8'(FALL_STEP);

  // Next y for the MOVE step, chosen by the latched controller mode.
  always_comb begin
    y_next = y;
    case (mode)
      M_START:   y_next = 7'(Y_START);
      M_RAISING: y_next = (y < 7'(Y_MIN + RISE_STEP)) ? 7'(Y_MIN) : y - 7'(RISE_STEP);
      M_FALLING: y_next = (fall_sum > 8'(Y_GROUND)) ? 7'(Y_GROUND) : fall_sum[6:0];
      default:   y_next = y;
    endcase
  end

  // Free-running frame counter; tick marks its last count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) frame_cnt <= '0;
    else if (tick) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + FCW'(1);
  end

  // Latch movement modes; DRAW/UPDATE/DEL and unknown codes keep the last mode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mode <= M_START;
    else if (state_in[3:2] == 2'b00) mode <= mode_t'(state_in[1:0]);
  end

  // Floor contact or pipe collision, one cycle behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) touched <= 1'b0;
    else touched <= (y >= 7'(Y_GROUND)) | pipe_hit;
  end

  // Erase / move / draw sequencer with registered pixel outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq        <= S_IDLE;
      cnt        <= '0;
      y          <= 7'(Y_START);
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      case (seq)
        S_IDLE: begin
          vga_plot <= 1'b0;
          if (tick) begin
            seq        <= S_ERASE;
            vga_plot   <= 1'b1;
            vga_x      <= 8'(X_POS);
            vga_y      <= y;
            vga_colour <= BG_COLOUR;
            cnt        <= CNTW'(1);
          end
        end
        S_ERASE: begin
          if (cnt == CNTW'(NPIX)) begin
            seq      <= S_MOVE;
            vga_plot <= 1'b0;
            y        <= y_next;
            cnt      <= '0;
          end else begin
            vga_plot <= 1'b1;
            vga_x    <= pix_x;
            vga_y    <= pix_y;
            cnt      <= cnt + CNTW'(1);
          end
        end
        S_MOVE: begin
          // y already holds the new position, so the first draw pixel uses it.
          seq        <= S_DRAW;
          vga_plot   <= 1'b1;
          vga_x      <= 8'(X_POS);
          vga_y      <= y;
          vga_colour <= BIRD_COLOUR;
          cnt        <= CNTW'(1);
        end
        default: begin
          if (cnt == CNTW'(NPIX)) begin
            seq      <= S_IDLE;
            vga_plot <= 1'b0;
            cnt      <= '0;
          end else begin
            vga_plot <= 1'b1;
            vga_x    <= pix_x;
            vga_y    <= pix_y;
            cnt      <= cnt + CNTW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath with a short frame period.
module tb_bird_datapath;

  logic       clk;
  logic       resetn;
  logic [3:0] state_in;
  logic       pipe_hit;
  logic       flag;
  logic       touched;
  logic [6:0] y_out;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Per-sequence observations filled by run_tick.
  int          plots;
  int          gaps;
  logic [17:0] pix_first;
  logic [17:0] pix_16;
  logic [17:0] pix_draw;
  logic        t_gap;
  logic        t_post;

  bird_datapath #(.FRAME_CYCLES(40)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .state_in   (state_in),
    .pipe_hit   (pipe_hit),
    .flag       (flag),
    .touched    (touched),
    .y_out      (y_out),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Wait for the next erase/move/draw sequence and record its pixel stream.
  task automatic run_tick();
    int  n;
    bit  got_draw;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      chk("tick_timeout", 32'd1, 32'd0);
      return;
    end
    plots = 0;
    gaps = 0;
    got_draw = 0;
    t_gap = 1'bx;
    t_post = 1'bx;
    n = 0;
    while (busy && n < 100) begin
      if (vga_plot) begin
        plots++;
        if (plots == 1) pix_first = {vga_x, vga_y, vga_colour};
        if (plots == 16) pix_16 = {vga_x, vga_y, vga_colour};
        if (gaps > 0 && !got_draw) begin
          pix_draw = {vga_x, vga_y, vga_colour};
          t_post = touched;
          got_draw = 1;
        end
      end else begin
        gaps++;
        t_gap = touched;
      end
      @(negedge clk);
      n++;
    end
    if (busy) chk("seq_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    state_in = 4'd2;
    pipe_hit = 1'b0;
    @(negedge clk);
    chk("rst_y", 32'(y_out), 32'd60);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_touched", 32'(touched), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    resetn = 1'b1;

    // Falling from 60: pixel order, plot count and gap per sequence.
    for (int i = 1; i <= 3; i++) begin
      run_tick();
      if (i == 1) begin
        chk("pix_first", 32'(pix_first), 32'({8'd40, 7'd60, 3'b000}));
        chk("pix_16", 32'(pix_16), 32'({8'd43, 7'd63, 3'b000}));
        chk("pix_draw", 32'(pix_draw), 32'({8'd40, 7'd61, 3'b110}));
      end
      chk("fall_plots", 32'(plots), 32'd32);
      chk("fall_gaps", 32'(gaps), 32'd1);
      chk("fall_y", 32'(y_out), 32'(60 + i));
    end

    // Rising from 63 to 9, then clamp at the ceiling.
    state_in = 4'd1;
    for (int i = 0; i < 27; i++) run_tick();
    chk("rise_y9", 32'(y_out), 32'd9);
    chk("rise_flag9", 32'(flag), 32'd0);
    run_tick();
    chk("ceil_y", 32'(y_out), 32'd8);
    chk("ceil_flag", 32'(flag), 32'd1);
    run_tick();
    chk("ceil_hold", 32'(y_out), 32'd8);

    // Code 4 must not disturb the latched FALLING mode.
    state_in = 4'd2;
    @(negedge clk);
    state_in = 4'd4;
    run_tick();
    chk("mode_hold", 32'(y_out), 32'd9);

    // Fall to 111, then clamp at the floor.
    for (int i = 0; i < 102; i++) run_tick();
    chk("fall_y111", 32'(y_out), 32'd111);
    run_tick();
    chk("floor_y", 32'(y_out), 32'd112);
    chk("floor_touch_move", 32'(t_gap), 32'd0);
    chk("floor_touch_next", 32'(t_post), 32'd1);
    run_tick();
    chk("floor_hold", 32'(y_out), 32'd112);
    chk("floor_touched", 32'(touched), 32'd1);

    // START reloads y and releases touched.
    state_in = 4'd0;
    run_tick();
    chk("start_y", 32'(y_out), 32'd60);
    @(negedge clk);
    chk("start_touched", 32'(touched), 32'd0);

    // Reset in the middle of a sequence.
    state_in = 4'd2;
    run_tick();
    chk("pre_rst_y", 32'(y_out), 32'd61);
    begin
      int n;
      n = 0;
      while (!busy && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("pre_rst_busy", 32'(busy), 32'd1);
    end
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_y", 32'(y_out), 32'd60);
    chk("mid_rst_plot", 32'(vga_plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_touched", 32'(touched), 32'd0);
    chk("mid_rst_flag", 32'(flag), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    state_in = 4'd0;

    // Single-cycle pipe hit gives a single-cycle touched.
    @(negedge clk);
    pipe_hit = 1'b1;
    @(negedge clk);
    pipe_hit = 1'b0;
    chk("pipe_touch", 32'(touched), 32'd1);
    @(negedge clk);
    chk("pipe_release", 32'(touched), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
